// File: rtl/seq_stim_gen.sv
// seq_stim_gen: serial stimulus transmitter for the sequence-detector FSMs.
// It accepts a pattern over a valid/ready handshake and shifts it out LSB-first
// on w, one bit per clock, for pat_rep+1 back-to-back passes. While the
// transmission runs, it counts the detector hits reported on z_in.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   pat_valid/pat_ready   pattern request handshake
//   pat_data [MAX_LEN]    pattern bits, bit 0 sent first
//   pat_len  [LEN_W]      bits per pass, clamped to MAX_LEN
//   pat_rep  [4]          extra passes (total passes = pat_rep+1)
//   z_in                  detector output, counted while busy
//   w, w_valid            registered serial bit and its qualifier
//   busy, done            transmission active / one-cycle end pulse
//   hit_cnt [CNT_W]       saturating hit count of the current or last run
module seq_stim_gen #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pat_valid,
  output logic               pat_ready,
  input  logic [MAX_LEN-1:0] pat_data,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [3:0]         pat_rep,
  input  logic               z_in,
  output logic               w,
  output logic               w_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int IDX_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t             state_q;
  logic [MAX_LEN-1:0] data_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [3:0]         rep_q;
  logic [3:0]         pass_q;
  logic [CNT_W-1:0]   hit_q;
  logic               w_q, w_valid_q, busy_q, done_q, ready_q;

  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   idx_d;
  logic               last_bit;

  assign len_c    = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
  assign idx_d    = idx_q + LEN_W'(1);
  assign last_bit = (idx_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      pass_q    <= '0;
      hit_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      // DONE is counted too, so a Moore hit on the final bit is not lost.
      if (state_q != IDLE && z_in && hit_q != '1)
        hit_q <= hit_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          if (pat_valid) begin
            data_q  <= pat_data;
            len_q   <= len_c;
            rep_q   <= pat_rep;
            idx_q   <= '0;
            pass_q  <= '0;
            hit_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (len_c == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              // First bit is presented in the cycle right after the accept.
              state_q   <= SEND;
              w_q       <= pat_data[0];
              w_valid_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (last_bit) begin
            if (pass_q == rep_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              w_q       <= 1'b0;
              w_valid_q <= 1'b0;
            end else begin
              // Wrap straight into the next pass with no gap cycle.
              idx_q  <= '0;
              pass_q <= pass_q + 4'd1;
              w_q    <= data_q[0];
            end
          end else begin
            idx_q <= idx_d;
            w_q   <= data_q[idx_d[IDX_W-1:0]];
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          w_q       <= 1'b0;
          w_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign pat_ready = ready_q;
  assign w         = w_q;
  assign w_valid   = w_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit_cnt   = hit_q;

endmodule

// File: tb/tb_seq_stim_gen.sv
module tb_seq_stim_gen;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               pat_valid = 1'b0;
  logic               pat_ready;
  logic [MAX_LEN-1:0] pat_data = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic [3:0]         pat_rep = '0;
  logic               z_in;
  logic               w, w_valid, busy, done;
  logic [CNT_W-1:0]   hit_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Detector models for "101" (overlapping) fed from w.
  logic [1:0] zsel = 2'd0;
  logic       z_force = 1'b0;
  logic [1:0] hist;
  logic       z_mealy, z_moore;

  seq_stim_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .pat_len(pat_len), .pat_rep(pat_rep), .z_in(z_in),
    .w(w), .w_valid(w_valid), .busy(busy), .done(done), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  assign z_mealy = w_valid && w && (hist == 2'b10);
  always @(posedge clk) begin
    hist    <= w_valid ? {hist[0], w} : 2'b00;
    z_moore <= z_mealy;
  end
  initial begin hist = 2'b00; z_moore = 1'b0; end
  assign z_in = (zsel == 2'd1) ? z_mealy : (zsel == 2'd2) ? z_moore : z_force;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] d, input int len, input int rep);
    pat_data  = d;
    pat_len   = LEN_W'(len);
    pat_rep   = 4'(rep);
    pat_valid = 1'b1;
    tick();
    pat_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    n_chk++;
    if ({pat_ready, w, w_valid, busy, done, hit_cnt} !== {1'b1, 4'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b w=%b wv=%b busy=%b done=%b hit=%0d want rdy=1 others 0",
               pat_ready, w, w_valid, busy, done, hit_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
    // Abort mid-transmission on the 3rd bit, with hits already counted.
    z_force = 1'b1;
    accept(16'hFFFF, 16, 0);
    tick();
    tick();
    n_chk++;
    if (w_valid !== 1'b1 || hit_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL pre_abort: got wv=%b hit=%0d want wv=1 hit=2", w_valid, hit_cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({pat_ready, w, w_valid, busy, done, hit_cnt} !== {1'b1, 4'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL abort_reset: got rdy=%b w=%b wv=%b busy=%b done=%b hit=%0d want rdy=1 others 0",
               pat_ready, w, w_valid, busy, done, hit_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    z_force = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: cycle %0d got done=%b busy=%b want 0,0", k, done, busy);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_w;
    exp_w = 4'b1011;
    accept(16'h000B, 4, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (w !== exp_w[i] || w_valid !== 1'b1 || busy !== 1'b1 || pat_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_bit%0d: got w=%b wv=%b busy=%b rdy=%b want w=%b wv=1 busy=1 rdy=0",
                 i, w, w_valid, busy, pat_ready, exp_w[i]);
      end
      tick();
    end
    n_chk++;
    if (done !== 1'b1 || w_valid !== 1'b0 || w !== 1'b0 || pat_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b wv=%b w=%b rdy=%b want 1,0,0,0", done, w_valid, w, pat_ready);
    end
    tick();
    n_chk++;
    if (pat_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got rdy=%b busy=%b done=%b want 1,0,0", pat_ready, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cyc;
    busy_cyc = 0;
    accept(16'h0001, 2, 2);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (w !== ((i % 2) == 0) || w_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reps_bit%0d: got w=%b wv=%b want w=%b wv=1", i, w, w_valid, (i % 2) == 0);
      end
      if (busy) busy_cyc++;
      tick();
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL reps_done: got done=%b want 1", done);
    end
    for (int i = 0; i < 5 && busy; i++) begin
      busy_cyc++;
      tick();
    end
    n_chk++;
    if (busy_cyc !== 7) begin
      n_fail++;
      $display("FAIL reps_busy_len: got %0d cycles want 7", busy_cyc);
    end
  endtask

  task automatic test_len_edges();
    int nbits;
    accept(16'hFFFF, 0, 3);
    n_chk++;
    if (done !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL len0_done: got done=%b wv=%b busy=%b want 1,0,1", done, w_valid, busy);
    end
    tick();
    n_chk++;
    if (pat_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_idle: got rdy=%b wv=%b busy=%b want 1,0,0", pat_ready, w_valid, busy);
    end
    nbits = 0;
    accept(16'hFFFF, 20, 0);
    for (int k = 0; k < 40 && !done; k++) begin
      if (w_valid) nbits++;
      tick();
    end
    n_chk++;
    if (nbits !== 16 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL len_clamp: got %0d bits done=%b want 16 bits done=1", nbits, done);
    end
    tick();
  endtask

  // Pattern 1,0,1,0,1,1,0,1 (LSB first) holds three "101", the last ending on the final bit.
  task automatic test_detector(input logic [1:0] sel, input string nm);
    zsel = sel;
    accept(16'h00B5, 8, 0);
    for (int k = 0; k < 30 && !done; k++) tick();
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: got done=%b want 1", nm, done);
    end
    tick();
    n_chk++;
    if (hit_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL %s_hits: got %0d want 3", nm, hit_cnt);
    end
    zsel = 2'd0;
  endtask

  task automatic test_saturate();
    int nbits;
    nbits = 0;
    z_force = 1'b1;
    accept(16'h5555, 16, 15);
    for (int k = 0; k < 300 && !done; k++) begin
      if (k == 2) begin
        pat_valid = 1'b1; pat_data = 16'h0000; pat_len = LEN_W'(3); pat_rep = 4'd0;
      end
      if (k == 12) pat_valid = 1'b0;
      if (k == 5) begin
        n_chk++;
        if (pat_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_ready_low: got rdy=%b want 0", pat_ready);
        end
      end
      if (w_valid) nbits++;
      tick();
    end
    n_chk++;
    if (nbits !== 256 || done !== 1'b1 || hit_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_run: got bits=%0d done=%b hit=%0d want 256,1,255", nbits, done, hit_cnt);
    end
    tick();
    tick();
    tick();
    n_chk++;
    if (hit_cnt !== 8'd255 || pat_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hold: got hit=%0d rdy=%b busy=%b want 255,1,0", hit_cnt, pat_ready, busy);
    end
    z_force = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_len_edges();
    test_detector(2'd1, "mealy");
    test_detector(2'd2, "moore");
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_stim_gen.md
# seq_stim_gen

Serial stimulus transmitter that produces the one-bit `w` stream consumed by the sequence-detector FSMs (Moore and Mealy). It accepts a bit pattern over a valid/ready handshake, shifts it out LSB-first one bit per clock for a programmable number of passes, and counts detector hits reported back on `z_in` during the transmission. It sits beside the detectors in the top-level and replaces hand-driven `w` stimulus.

## Interface
- `MAX_LEN`, 16, maximum pattern length in bits (≥2).
- `LEN_W`, $clog2(MAX_LEN)+1, width of the length field.
- `CNT_W`, 8, width of the hit counter.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pat_valid` in 1: pattern request valid.
- `pat_ready` out 1: block can accept a pattern.
- `pat_data` in MAX_LEN: pattern bits; bit 0 is sent first.
- `pat_len` in LEN_W: bits per pass, 0..MAX_LEN. Values above MAX_LEN are clamped to MAX_LEN.
- `pat_rep` in 4: extra passes; total passes = `pat_rep`+1.
- `z_in` in 1: detector output fed back for counting.
- `w` out 1: serial stimulus bit, registered.
- `w_valid` out 1: `w` carries a pattern bit this cycle.
- `busy` out 1: transmission in progress (SEND or DONE).
- `done` out 1: one-cycle pulse at end of transmission.
- `hit_cnt` out CNT_W: saturating count of `z_in` highs in the current or last transmission.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - `pat_ready`=1.
  - On `pat_valid`:
    - Latch `pat_data`, clamped `pat_len` and `pat_rep`.
    - Clear `hit_cnt`, bit index and pass counter.
    - If length is 0, go to DONE; otherwise go to SEND.
- SEND:
  - `w` = latched bit[idx]; `w_valid`=1.
  - Each cycle, idx increments.
  - When idx = len−1:
    - If pass = rep, go to DONE.
    - Else set idx=0 and increment pass; there is no gap cycle between passes.
  - `pat_ready`=0; `pat_valid` is ignored.
- DONE:
  - `done`=1, `w`=0, `w_valid`=0.
  - Unconditional return to IDLE next cycle.
- `hit_cnt` increments on every cycle with `z_in`=1 while in SEND or DONE. DONE is included so a Moore detector's one-cycle-late output on the final bit is counted.
- `hit_cnt` saturates at 2^CNT_W−1.
- `hit_cnt` holds its value in IDLE until the next accepted pattern.
- `w` and `w_valid` are 0 in IDLE and DONE.
- `busy` = (state ≠ IDLE).

## Timing
- Reset, asynchronous and immediate: state IDLE; `pat_ready`=1; `w`=0, `w_valid`=0, `busy`=0, `done`=0, `hit_cnt`=0.
- A reset asserted mid-transmission aborts it, with no `done` pulse.
- A handshake is accepted on a rising edge where `pat_valid` && `pat_ready`.
- First bit timing: the first bit appears on `w` (with `w_valid`=1) in the cycle after the accepting edge.
- A transmission has N = len·(rep+1) SEND cycles, followed by exactly one DONE cycle.
- `pat_ready` returns to 1 the cycle after DONE. The minimum accept-to-accept spacing is N+2 cycles.
- len=0 transmission: accept, then DONE for one cycle, then IDLE; `w_valid` is never asserted.
- `z_in` is sampled every edge. A Mealy hit on the last bit is counted in the last SEND cycle; a Moore hit on the last bit is counted in the DONE cycle.

## Test plan
- Reset mid-SEND (assert `rst` on the 3rd bit of a 16-bit pattern) → outputs return to reset values immediately; no `done`; next accept behaves normally.
- Pattern 0b1011, len=4, rep=0 → `w` = 1,1,0,1 in cycles 1–4 after accept with `w_valid`=1; `done` in cycle 5; `pat_ready`=1 in cycle 6.
- Pattern 0b01, len=2, rep=2 → `w` = 1,0,1,0,1,0 contiguous, then `done`; `busy` high for 7 cycles.
- len=0 and len=20 with MAX_LEN=16 → len=0: `done` in the cycle after accept, no `w_valid`; len=20: exactly 16 bits sent.
- Loop `w` into the Moore and Mealy detectors with a pattern that contains 3 target sequences → `hit_cnt`=3 for each detector, including a hit completed on the final bit.
- CNT_W=2, `z_in` held high through a 16-bit pass → `hit_cnt` saturates at 3, then holds after `done`; `pat_valid` asserted during SEND is ignored.
